// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage with 32x32 register file and RAW scoreboard.
// Optional same-cycle writeback forwarding is enabled by defining DECODE_STAGE_BYPASS_EN.
//
// Ports:
//   clk, reset (async, active-high)
//   instr_valid/instr_ready/instr/instr_pc : upstream instruction handshake
//   out_valid/out_ready                    : downstream ALU command handshake
//   alu_command, alu_lhs, alu_rhs          : registered ALU command and operands
//   out_rd, out_wb_en, out_is_branch       : destination / branch info
//   out_branch_target, out_pc              : pc + B-immediate, instruction pc
//   wb_en, wb_rd, wb_data                  : register file writeback port
//   illegal                                : one-cycle pulse after an unsupported instr is consumed
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] instr_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_command,
    output logic [31:0] alu_lhs,
    output logic [31:0] alu_rhs,
    output logic [4:0]  out_rd,
    output logic        out_wb_en,
    output logic        out_is_branch,
    output logic [31:0] out_branch_target,
    output logic [31:0] out_pc,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] CMD_ADD = 4'd0;
    localparam logic [3:0] CMD_SUB = 4'd1;
    localparam logic [3:0] CMD_AND = 4'd2;
    localparam logic [3:0] CMD_OR  = 4'd3;
    localparam logic [3:0] CMD_XOR = 4'd4;
    localparam logic [3:0] CMD_SLL = 4'd5;
    localparam logic [3:0] CMD_SRL = 4'd6;
    localparam logic [3:0] CMD_SRA = 4'd7;
    localparam logic [3:0] CMD_EQ  = 4'd8;
    localparam logic [3:0] CMD_NE  = 4'd9;
    localparam logic [3:0] CMD_LT  = 4'd10;
    localparam logic [3:0] CMD_LTU = 4'd11;
    localparam logic [3:0] CMD_GE  = 4'd12;
    localparam logic [3:0] CMD_GEU = 4'd13;

    typedef enum logic [1:0] {
        LHS_RS1,
        LHS_ZERO,
        LHS_PC
    } lhs_sel_e;

    typedef enum logic [2:0] {
        RHS_RS2,
        RHS_RS2_SHAMT,
        RHS_IMM_I,
        RHS_SHAMT_I,
        RHS_IMM_U
    } rhs_sel_e;

    // instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic        f7_zero;
    logic        f7_alt;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_b;

    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign f3      = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign f7      = instr[31:25];
    assign f7_zero = (f7 == 7'h00);
    assign f7_alt  = (f7 == 7'h20);
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_u   = {instr[31:12], 12'b0};
    assign imm_b   = {{19{instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};

    // decode results
    logic        dec_legal;
    logic [3:0]  dec_cmd;
    logic        use_rs1;
    logic        use_rs2;
    logic        dec_wb;
    logic        dec_br;
    lhs_sel_e    lhs_sel;
    rhs_sel_e    rhs_sel;

    always_comb begin
        dec_legal = 1'b0;
        dec_cmd   = CMD_ADD;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        dec_wb    = 1'b0;
        dec_br    = 1'b0;
        lhs_sel   = LHS_RS1;
        rhs_sel   = RHS_RS2;
        unique case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_wb  = (rd != 5'd0);
                unique case (f3)
                    3'b000: begin
                        dec_legal = f7_zero || f7_alt;
                        dec_cmd   = f7_alt ? CMD_SUB : CMD_ADD;
                    end
                    3'b001: begin
                        dec_legal = f7_zero;
                        dec_cmd   = CMD_SLL;
                        rhs_sel   = RHS_RS2_SHAMT;
                    end
                    3'b010: begin
                        dec_legal = f7_zero;
                        dec_cmd   = CMD_LT;
                    end
                    3'b011: begin
                        dec_legal = f7_zero;
                        dec_cmd   = CMD_LTU;
                    end
                    3'b100: begin
                        dec_legal = f7_zero;
                        dec_cmd   = CMD_XOR;
                    end
                    3'b101: begin
                        dec_legal = f7_zero || f7_alt;
                        dec_cmd   = f7_alt ? CMD_SRA : CMD_SRL;
                        rhs_sel   = RHS_RS2_SHAMT;
                    end
                    3'b110: begin
                        dec_legal = f7_zero;
                        dec_cmd   = CMD_OR;
                    end
                    default: begin
                        dec_legal = f7_zero;
                        dec_cmd   = CMD_AND;
                    end
                endcase
            end
            OPC_OPIMM: begin
                use_rs1   = 1'b1;
                dec_wb    = (rd != 5'd0);
                dec_legal = 1'b1;
                rhs_sel   = RHS_IMM_I;
                unique case (f3)
                    3'b000: dec_cmd = CMD_ADD;
                    3'b001: begin
                        dec_legal = f7_zero;
                        dec_cmd   = CMD_SLL;
                        rhs_sel   = RHS_SHAMT_I;
                    end
                    3'b010: dec_cmd = CMD_LT;
                    3'b011: dec_cmd = CMD_LTU;
                    3'b100: dec_cmd = CMD_XOR;
                    3'b101: begin
                        dec_legal = f7_zero || f7_alt;
                        dec_cmd   = f7_alt ? CMD_SRA : CMD_SRL;
                        rhs_sel   = RHS_SHAMT_I;
                    end
                    3'b110: dec_cmd = CMD_OR;
                    default: dec_cmd = CMD_AND;
                endcase
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_wb    = (rd != 5'd0);
                lhs_sel   = LHS_ZERO;
                rhs_sel   = RHS_IMM_U;
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_wb    = (rd != 5'd0);
                lhs_sel   = LHS_PC;
                rhs_sel   = RHS_IMM_U;
            end
            OPC_BRANCH: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                dec_br    = 1'b1;
                dec_legal = 1'b1;
                unique case (f3)
                    3'b000: dec_cmd = CMD_EQ;
                    3'b001: dec_cmd = CMD_NE;
                    3'b100: dec_cmd = CMD_LT;
                    3'b101: dec_cmd = CMD_GE;
                    3'b110: dec_cmd = CMD_LTU;
                    3'b111: dec_cmd = CMD_GEU;
                    default: dec_legal = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // register file and scoreboard
    logic [31:0] rf [32];
    logic [31:0] busy;
    logic [31:0] busy_nxt;
    logic [31:0] busy_eff;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

`ifdef DECODE_STAGE_BYPASS_EN
    // A writeback landing this cycle releases its register immediately.
    logic [31:0] wb_clr;
    assign wb_clr   = wb_en ? (32'd1 << wb_rd) : 32'd0;
    assign busy_eff = busy & ~wb_clr;

    always_comb begin
        rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
        rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
        if (wb_en && wb_rd == rs1 && rs1 != 5'd0)
            rs1_val = wb_data;
        if (wb_en && wb_rd == rs2 && rs2 != 5'd0)
            rs2_val = wb_data;
    end
`else
    assign busy_eff = busy;

    always_comb begin
        rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
        rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
    end
`endif

    logic hazard;
    logic accept;

    // Illegal words never issue, so they are not held back by busy registers.
    assign hazard = dec_legal &&
                    ((use_rs1 && busy_eff[rs1]) ||
                     (use_rs2 && busy_eff[rs2]));
    assign instr_ready = (!out_valid || out_ready) && !hazard;
    assign accept      = instr_valid && instr_ready;

    // operand selection
    logic [31:0] lhs_val;
    logic [31:0] rhs_val;

    always_comb begin
        lhs_val = rs1_val;
        unique case (lhs_sel)
            LHS_ZERO: lhs_val = 32'd0;
            LHS_PC:   lhs_val = instr_pc;
            default:  lhs_val = rs1_val;
        endcase
        rhs_val = rs2_val;
        unique case (rhs_sel)
            RHS_RS2_SHAMT: rhs_val = {27'b0, rs2_val[4:0]};
            RHS_IMM_I:     rhs_val = imm_i;
            RHS_SHAMT_I:   rhs_val = {27'b0, rs2};
            RHS_IMM_U:     rhs_val = imm_u;
            default:       rhs_val = rs2_val;
        endcase
    end

    // Set beats clear when the same register is written back and re-claimed.
    always_comb begin
        busy_nxt = busy;
        if (wb_en)
            busy_nxt[wb_rd] = 1'b0;
        if (accept && dec_legal && dec_wb)
            busy_nxt[rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= 32'd0;
        end else if (wb_en && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid         <= 1'b0;
            alu_command       <= 4'd0;
            alu_lhs           <= 32'd0;
            alu_rhs           <= 32'd0;
            out_rd            <= 5'd0;
            out_wb_en         <= 1'b0;
            out_is_branch     <= 1'b0;
            out_branch_target <= 32'd0;
            out_pc            <= 32'd0;
            illegal           <= 1'b0;
        end else begin
            illegal <= accept && !dec_legal;
            if (accept && dec_legal) begin
                out_valid         <= 1'b1;
                alu_command       <= dec_cmd;
                alu_lhs           <= lhs_val;
                alu_rhs           <= rhs_val;
                out_rd            <= dec_wb ? rd : 5'd0;
                out_wb_en         <= dec_wb;
                out_is_branch     <= dec_br;
                out_branch_target <= dec_br ? (instr_pc + imm_b) : 32'd0;
                out_pc            <= instr_pc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table, corner sequences,
// and randomized instructions checked against a field-level model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_command;
    logic [31:0] alu_lhs;
    logic [31:0] alu_rhs;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_is_branch;
    logic [31:0] out_branch_target;
    logic [31:0] out_pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    decode_stage dut (
        .clk               (clk),
        .reset             (reset),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instr             (instr),
        .instr_pc          (instr_pc),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .alu_command       (alu_command),
        .alu_lhs           (alu_lhs),
        .alu_rhs           (alu_rhs),
        .out_rd            (out_rd),
        .out_wb_en         (out_wb_en),
        .out_is_branch     (out_is_branch),
        .out_branch_target (out_branch_target),
        .out_pc            (out_pc),
        .wb_en             (wb_en),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .illegal           (illegal)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_rf [32];

    // OP: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
    localparam logic [2:0] OP_F3  [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    localparam logic [6:0] OP_F7  [10] = '{0, 7'h20, 0, 0, 0, 0, 0, 7'h20, 0, 0};
    localparam logic [3:0] OP_CMD [10] = '{0, 1, 5, 10, 11, 4, 6, 7, 3, 2};
    localparam logic       OP_SH  [10] = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 0};
    // OP-IMM: ADDI SLTI SLTIU XORI ORI ANDI
    localparam logic [2:0] OPI_F3  [6] = '{0, 2, 3, 4, 6, 7};
    localparam logic [3:0] OPI_CMD [6] = '{0, 10, 11, 4, 3, 2};
    // SLLI SRLI SRAI
    localparam logic [2:0] SHI_F3  [3] = '{1, 5, 5};
    localparam logic [6:0] SHI_F7  [3] = '{0, 0, 7'h20};
    localparam logic [3:0] SHI_CMD [3] = '{5, 6, 7};
    // BEQ BNE BLT BGE BLTU BGEU
    localparam logic [2:0] BR_F3  [6] = '{0, 1, 4, 5, 6, 7};
    localparam logic [3:0] BR_CMD [6] = '{8, 9, 10, 12, 11, 13};

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2,
                                          logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd,
                                          logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_b(int off, logic [4:0] rs2,
                                          logic [4:0] rs1, logic [2:0] f3);
        logic [12:0] o;
        o = off[12:0];
        return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'h63};
    endfunction

    function automatic logic [139:0] got();
        return {out_valid, alu_command, alu_lhs, alu_rhs, out_rd, out_wb_en,
                out_is_branch, out_branch_target, out_pc};
    endfunction

    function automatic logic [139:0] mk(logic [3:0] c, logic [31:0] l,
                                        logic [31:0] r, logic [4:0] d,
                                        logic w, logic b, logic [31:0] t,
                                        logic [31:0] p);
        return {1'b1, c, l, r, d, w, b, t, p};
    endfunction

    task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(logic [31:0] w, logic [31:0] pc);
        int n;
        @(negedge clk);
        instr = w;
        instr_pc = pc;
        instr_valid = 1'b1;
        #1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: instr_ready 0 after 20 cycles, required 1");
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic do_wb(logic [4:0] r, logic [31:0] d);
        @(negedge clk);
        wb_en = 1'b1;
        wb_rd = r;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        if (r != 5'd0)
            m_rf[r] = d;
    endtask

    typedef struct {
        string       nm;
        logic [31:0] w;
        logic [31:0] pc;
        logic        ill;
        logic [3:0]  cmd;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [4:0]  rd;
        logic        wb;
        logic        br;
        logic [31:0] tgt;
    } vec_t;

    function automatic vec_t mkv(string nm, logic [31:0] w, logic [31:0] pc,
                                 logic ill, logic [3:0] cmd, logic [31:0] lhs,
                                 logic [31:0] rhs, logic [4:0] rd, logic wb,
                                 logic br, logic [31:0] tgt);
        vec_t v;
        v.nm = nm; v.w = w; v.pc = pc; v.ill = ill; v.cmd = cmd;
        v.lhs = lhs; v.rhs = rhs; v.rd = rd; v.wb = wb; v.br = br;
        v.tgt = tgt;
        return v;
    endfunction

    task automatic run_random(int n);
        logic [31:0] w, pc, lhs, rhs, tgt;
        logic [3:0]  cmd;
        logic [4:0]  rd, rs1, rs2;
        logic        wb, br, ill;
        logic [11:0] imm;
        logic [19:0] u;
        int kind, k, off, iv;
        for (int i = 0; i < n; i++) begin
            rd  = 5'($urandom);
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            pc  = $urandom & 32'hFFFF_FFFC;
            ill = 1'b0;
            br  = 1'b0;
            tgt = 32'd0;
            wb  = (rd != 5'd0);
            lhs = m_rf[rs1];
            rhs = m_rf[rs2];
            cmd = 4'd0;
            w   = 32'd0;
            kind = int'($urandom_range(0, 6));
            case (kind)
                0: begin
                    k = int'($urandom_range(0, 9));
                    w = enc_r(OP_F7[k], rs2, rs1, OP_F3[k], rd);
                    cmd = OP_CMD[k];
                    if (OP_SH[k])
                        rhs = m_rf[rs2] % 32;
                end
                1: begin
                    k = int'($urandom_range(0, 5));
                    imm = 12'($urandom);
                    iv = int'(imm);
                    if (iv >= 2048)
                        iv -= 4096;
                    w = enc_i(imm, rs1, OPI_F3[k], rd, 7'h13);
                    cmd = OPI_CMD[k];
                    rhs = 32'(iv);
                end
                2: begin
                    k = int'($urandom_range(0, 2));
                    iv = int'($urandom_range(0, 31));
                    w = enc_i({SHI_F7[k], 5'(iv)}, rs1, SHI_F3[k], rd, 7'h13);
                    cmd = SHI_CMD[k];
                    rhs = 32'(iv);
                end
                3: begin
                    u = 20'($urandom);
                    w = {u, rd, 7'h37};
                    lhs = 32'd0;
                    rhs = 32'(u) * 4096;
                end
                4: begin
                    u = 20'($urandom);
                    w = {u, rd, 7'h17};
                    lhs = pc;
                    rhs = 32'(u) * 4096;
                end
                5: begin
                    k = int'($urandom_range(0, 5));
                    off = (int'($urandom_range(0, 4095)) - 2048) * 2;
                    w = enc_b(off, rs2, rs1, BR_F3[k]);
                    cmd = BR_CMD[k];
                    br = 1'b1;
                    wb = 1'b0;
                    tgt = pc + 32'(off);
                end
                default: begin
                    ill = 1'b1;
                    wb = 1'b0;
                    k = int'($urandom_range(0, 5));
                    case (k)
                        0: w = 32'h0000_006F;
                        1: w = enc_r(7'h01, rs2, rs1, 3'($urandom), rd);
                        2: w = enc_r(7'h20, rs2, rs1, 3'd1, rd);
                        3: w = enc_i({7'h10, rs2}, rs1, 3'd5, rd, 7'h13);
                        4: w = enc_b(8, rs2, rs1, 3'd2);
                        default: w = {25'($urandom), 7'h03};
                    endcase
                end
            endcase
            issue(w, pc);
            if (ill)
                chk("rand_illegal", {158'd0, out_valid, illegal}, 160'b01);
            else
                chk("rand_decode", got(),
                    mk(cmd, lhs, rhs, wb ? rd : 5'd0, wb, br, tgt, pc));
            if (wb)
                do_wb(rd, $urandom);
        end
    endtask

    vec_t v [$];
    logic [139:0] e1, e2;

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 32'd0;
        instr_pc = 32'd0;
        out_ready = 1'b1;
        wb_en = 1'b0;
        wb_rd = 5'd0;
        wb_data = 32'd0;
        for (int i = 0; i < 32; i++)
            m_rf[i] = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", {got(), illegal}, 160'd0);
        chk("reset_ready", {159'd0, instr_ready}, 160'd1);
        @(negedge clk);
        reset = 1'b0;

        // ADDI x1, x0, 5
        issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 32'h0);
        chk("addi_first", got(), mk(4'd0, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0, 32'd0, 32'h0));

        // ADD x2, x1, x1 stalls on x1 until writeback
        @(negedge clk);
        instr = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
        instr_pc = 32'h4;
        instr_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("raw_stall", {159'd0, instr_ready}, 160'd0);
            @(negedge clk);
        end
        wb_en = 1'b1;
        wb_rd = 5'd1;
        wb_data = 32'd5;
        #1;
`ifdef DECODE_STAGE_BYPASS_EN
        chk("raw_wb_cycle_ready", {159'd0, instr_ready}, 160'd1);
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        m_rf[1] = 32'd5;
`else
        chk("raw_wb_cycle_ready", {159'd0, instr_ready}, 160'd0);
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        m_rf[1] = 32'd5;
        chk("raw_not_yet", {159'd0, out_valid}, 160'd0);
        @(negedge clk);
        #1;
        chk("raw_next_ready", {159'd0, instr_ready}, 160'd1);
        @(posedge clk);
        #1;
`endif
        instr_valid = 1'b0;
        chk("raw_add", got(), mk(4'd0, 32'd5, 32'd5, 5'd2, 1'b1, 1'b0, 32'd0, 32'h4));
        do_wb(5'd2, 32'd10);

        // table of single-instruction decodes
        for (int r = 1; r < 32; r++)
            do_wb(5'(r), 32'(r) * 32'h1111_1111);
        v.push_back(mkv("add", enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd8), 32'h100, 0,
                        4'd0, 32'h1111_1111, 32'h2222_2222, 5'd8, 1, 0, 0));
        v.push_back(mkv("sub", enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd9), 32'h100, 0,
                        4'd1, 32'h2222_2222, 32'h1111_1111, 5'd9, 1, 0, 0));
        v.push_back(mkv("sra", enc_r(7'h20, 5'd3, 5'd15, 3'd5, 5'd10), 32'h100, 0,
                        4'd7, 32'hFFFF_FFFF, 32'd19, 5'd10, 1, 0, 0));
        v.push_back(mkv("sltu_x0", enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd0), 32'h100, 0,
                        4'd11, 32'h1111_1111, 32'h2222_2222, 5'd0, 0, 0, 0));
        v.push_back(mkv("addi_neg", enc_i(12'hFFF, 5'd4, 3'd0, 5'd11, 7'h13), 32'h100, 0,
                        4'd0, 32'h4444_4444, 32'hFFFF_FFFF, 5'd11, 1, 0, 0));
        v.push_back(mkv("srai", enc_i({7'h20, 5'd31}, 5'd5, 3'd5, 5'd12, 7'h13), 32'h100, 0,
                        4'd7, 32'h5555_5555, 32'd31, 5'd12, 1, 0, 0));
        v.push_back(mkv("lui", {20'hABCDE, 5'd13, 7'h37}, 32'h100, 0,
                        4'd0, 32'd0, 32'hABCD_E000, 5'd13, 1, 0, 0));
        v.push_back(mkv("auipc", {20'h00001, 5'd14, 7'h17}, 32'h200, 0,
                        4'd0, 32'h200, 32'h1000, 5'd14, 1, 0, 0));
        v.push_back(mkv("bltu_back", enc_b(-8, 5'd4, 5'd3, 3'd6), 32'h100, 0,
                        4'd11, 32'h3333_3333, 32'h4444_4444, 5'd0, 0, 1, 32'hF8));
        v.push_back(mkv("bgeu_fwd", enc_b(16, 5'd1, 5'd7, 3'd7), 32'h100, 0,
                        4'd13, 32'h7777_7777, 32'h1111_1111, 5'd0, 0, 1, 32'h110));
        v.push_back(mkv("ill_jal", 32'h0000_006F, 32'h100, 1, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mkv("ill_srli_f7", enc_i({7'h10, 5'd3}, 5'd1, 3'd5, 5'd16, 7'h13),
                        32'h100, 1, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mkv("ill_mul", enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd17), 32'h100, 1,
                        0, 0, 0, 0, 0, 0, 0));
        v.push_back(mkv("ill_sll_f7", enc_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd18), 32'h100, 1,
                        0, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            issue(v[i].w, v[i].pc);
            if (v[i].ill)
                chk(v[i].nm, {158'd0, out_valid, illegal}, 160'b01);
            else
                chk(v[i].nm, got(), mk(v[i].cmd, v[i].lhs, v[i].rhs, v[i].rd,
                                       v[i].wb, v[i].br, v[i].tgt, v[i].pc));
        end

        // BLTU x3, x4, -8 at 0x100 with x3=1, x4=2
        do_wb(5'd3, 32'd1);
        do_wb(5'd4, 32'd2);
        issue(enc_b(-8, 5'd4, 5'd3, 3'd6), 32'h100);
        chk("bltu_plan", got(), mk(4'd11, 32'd1, 32'd2, 5'd0, 1'b0, 1'b1, 32'hF8, 32'h100));
        @(posedge clk);
        #1;

        // backpressure: hold for 3 cycles with a second instruction waiting
        out_ready = 1'b0;
        e1 = mk(4'd0, 32'd0, 32'd7, 5'd20, 1'b1, 1'b0, 32'd0, 32'h300);
        e2 = mk(4'd0, 32'd0, 32'd9, 5'd21, 1'b1, 1'b0, 32'd0, 32'h304);
        issue(enc_i(12'd7, 5'd0, 3'd0, 5'd20, 7'h13), 32'h300);
        @(negedge clk);
        instr = enc_i(12'd9, 5'd0, 3'd0, 5'd21, 7'h13);
        instr_pc = 32'h304;
        instr_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("hold_out", got(), e1);
            chk("hold_ready", {159'd0, instr_ready}, 160'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", {159'd0, instr_ready}, 160'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("release_second", got(), e2);
        @(posedge clk);
        #1;
        chk("release_drain", {159'd0, out_valid}, 160'd0);

        // JAL x23: illegal pulse, no output, x23 not claimed
        issue(32'h0000_0BEF, 32'h400);
        chk("jal_illegal", {158'd0, out_valid, illegal}, 160'b01);
        @(posedge clk);
        #1;
        chk("illegal_one_pulse", {159'd0, illegal}, 160'd0);
        @(negedge clk);
        instr = enc_r(7'h00, 5'd0, 5'd23, 3'd0, 5'd24);
        instr_pc = 32'h404;
        instr_valid = 1'b1;
        #1;
        chk("jal_no_scoreboard", {159'd0, instr_ready}, 160'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;

        // randomized decode against the model
        for (int r = 1; r < 32; r++)
            do_wb(5'(r), $urandom);
        run_random(300);

        // reset while an output is pending and x5 is busy
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(enc_i(12'd1, 5'd0, 3'd0, 5'd5, 7'h13), 32'h500);
        chk("pre_reset_valid", {159'd0, out_valid}, 160'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_async", {got(), illegal}, 160'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        instr = enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd6);
        instr_pc = 32'h600;
        instr_valid = 1'b1;
        #1;
        chk("post_reset_ready", {159'd0, instr_ready}, 160'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("post_reset_add", got(), mk(4'd0, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0, 32'd0, 32'h600));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
